// File: rtl/multi_cycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller side drives every control line; the datapath returns opcode and ALU flags.
interface multi_cycle_ctrl_if #(
    parameter int STATE_W = 3
);
    logic [5:0]         op;
    logic               zero;
    logic               sign;
    logic [STATE_W-1:0] state;
    logic               PCWre;
    logic               IRWre;
    logic               InsMemRW;
    logic               ExtSel;
    logic               ALUSrcA;
    logic               ALUSrcB;
    logic [2:0]         ALUOp;
    logic               mRD;
    logic               mWR;
    logic               DBDataSrc;
    logic               RegWre;
    logic [1:0]         RegDst;
    logic               WrRegDSrc;
    logic [1:0]         PCSrc;

    modport master (
        input  op, zero, sign,
        output state, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
               mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc
    );

    modport slave (
        output op, zero, sign,
        input  state, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
               mRD, mWR, DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: steps each instruction through IF/ID/EXE/MEM/WB and
// decodes datapath controls combinationally from the current state and opcode.
module multi_cycle_ctrl #(
    parameter int STATE_W = 3
) (
    input  logic               CLK,
    input  logic               Reset,
    multi_cycle_ctrl_if.master bus
);
    typedef enum logic [STATE_W-1:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t state_q;
    state_t state_d;

    logic is_rtype;
    logic is_imm;
    logic is_branch;
    logic is_ls;
    logic is_sw;
    logic is_lw;
    logic is_jump;
    logic is_halt;
    logic is_legal;
    logic br_taken;

    logic pc_wre;
    logic ir_wre;
    logic reg_wre;
    logic m_rd;
    logic m_wr;

    always_comb begin
        is_rtype  = (bus.op == OP_ADD) || (bus.op == OP_SUB) || (bus.op == OP_OR) ||
                    (bus.op == OP_AND) || (bus.op == OP_SLL) || (bus.op == OP_SLT);
        is_imm    = (bus.op == OP_ADDI) || (bus.op == OP_ORI) || (bus.op == OP_SLTI);
        is_sw     = (bus.op == OP_SW);
        is_lw     = (bus.op == OP_LW);
        is_ls     = is_sw || is_lw;
        is_branch = (bus.op == OP_BEQ) || (bus.op == OP_BNE) || (bus.op == OP_BLTZ);
        is_jump   = (bus.op == OP_J) || (bus.op == OP_JR) || (bus.op == OP_JAL);
        is_halt   = (bus.op == OP_HALT);
        is_legal  = is_rtype || is_imm || is_ls || is_branch || is_jump || is_halt;
        br_taken  = ((bus.op == OP_BEQ)  &&  bus.zero) ||
                    ((bus.op == OP_BNE)  && !bus.zero) ||
                    ((bus.op == OP_BLTZ) &&  bus.sign);
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:     state_d = S_ID;
            S_ID: begin
                if (is_halt)                    state_d = S_ID;
                else if (is_jump || !is_legal)  state_d = S_IF;
                else if (is_branch)             state_d = S_EXE_BR;
                else if (is_ls)                 state_d = S_EXE_LS;
                else                            state_d = S_EXE_AL;
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL:  state_d = S_IF;
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
            S_WB_LD:  state_d = S_IF;
            default:  state_d = S_IF;
        endcase
    end

    // Raw decode; write/load strobes are masked by Reset below so an abort leaves no write.
    always_comb begin
        pc_wre        = 1'b0;
        ir_wre        = 1'b0;
        reg_wre       = 1'b0;
        m_rd          = 1'b0;
        m_wr          = 1'b0;
        bus.DBDataSrc = 1'b0;
        bus.PCSrc     = 2'b00;
        bus.InsMemRW  = 1'b1;
        bus.ExtSel    = (bus.op != OP_ORI);
        bus.ALUSrcA   = (bus.op == OP_SLL);
        bus.ALUSrcB   = is_imm || is_ls;
        bus.WrRegDSrc = (bus.op != OP_JAL);
        if (bus.op == OP_JAL)  bus.RegDst = 2'b00;
        else if (is_rtype)     bus.RegDst = 2'b10;
        else                   bus.RegDst = 2'b01;

        case (bus.op)
            OP_SUB, OP_BEQ, OP_BNE:     bus.ALUOp = 3'b001;
            OP_SLL:                     bus.ALUOp = 3'b010;
            OP_OR, OP_ORI:              bus.ALUOp = 3'b011;
            OP_AND:                     bus.ALUOp = 3'b100;
            OP_SLT, OP_SLTI, OP_BLTZ:   bus.ALUOp = 3'b101;
            default:                    bus.ALUOp = 3'b000;
        endcase

        case (state_q)
            S_IF: ir_wre = 1'b1;
            S_ID: begin
                pc_wre  = (is_jump || !is_legal) && !is_halt;
                reg_wre = (bus.op == OP_JAL);
                if ((bus.op == OP_J) || (bus.op == OP_JAL)) bus.PCSrc = 2'b11;
                else if (bus.op == OP_JR)                  bus.PCSrc = 2'b10;
            end
            S_EXE_BR: begin
                pc_wre    = 1'b1;
                bus.PCSrc = br_taken ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                pc_wre        = is_sw;
                m_wr          = is_sw;
                m_rd          = is_lw;
                bus.DBDataSrc = is_lw;
            end
            S_WB_LD: begin
                pc_wre        = 1'b1;
                reg_wre       = 1'b1;
                bus.DBDataSrc = is_lw;
            end
            S_WB_AL: begin
                pc_wre  = 1'b1;
                reg_wre = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.state  = state_q;
    assign bus.PCWre  = pc_wre  & Reset;
    assign bus.IRWre  = ir_wre  & Reset;
    assign bus.RegWre = reg_wre & Reset;
    assign bus.mRD    = m_rd    & Reset;
    assign bus.mWR    = m_wr    & Reset;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed instruction walks plus random instructions checked
// against a per-instruction state-sequence model.
module tb_multi_cycle_ctrl;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
    localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010, SLL = 6'b011000;
    localparam logic [5:0] SLT = 6'b100110, SLTI = 6'b100111, SW = 6'b110000, LW = 6'b110001;
    localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

    localparam int C_ALU = 0, C_BR = 1, C_SW = 2, C_LW = 3, C_JMP = 4, C_ILL = 5, C_HALT = 6;

    logic CLK = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad = 0;

    always #5 CLK = ~CLK;

    multi_cycle_ctrl_if #(.STATE_W(3)) bus ();
    multi_cycle_ctrl #(.STATE_W(3)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    logic [5:0] legal_ops [17] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTI,
                                   SW, LW, BEQ, BNE, BLTZ, J, JR, JAL};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] o);
        case (o)
            ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTI: return C_ALU;
            BEQ, BNE, BLTZ: return C_BR;
            SW:             return C_SW;
            LW:             return C_LW;
            J, JR, JAL:     return C_JMP;
            HALT:           return C_HALT;
            default:        return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] exp_aluop(input logic [5:0] o);
        if (o == SUB || o == BEQ || o == BNE) return 3'b001;
        if (o == SLL) return 3'b010;
        if (o == OR_ || o == ORI) return 3'b011;
        if (o == AND_) return 3'b100;
        if (o == SLT || o == SLTI || o == BLTZ) return 3'b101;
        return 3'b000;
    endfunction

    // Walks one instruction from IF; the IF cycle begins at the next posedge.
    task automatic do_instr(input logic [5:0] o, input logic z, input logic s, input bit rel);
        logic [2:0] seq [$];
        int cls;
        bit last, rw, taken;
        logic [1:0] pcs;
        cls = classify(o);
        seq.push_back(3'b000);
        seq.push_back(3'b001);
        case (cls)
            C_ALU: begin seq.push_back(3'b110); seq.push_back(3'b111); end
            C_BR:  seq.push_back(3'b101);
            C_SW:  begin seq.push_back(3'b010); seq.push_back(3'b011); end
            C_LW:  begin seq.push_back(3'b010); seq.push_back(3'b011); seq.push_back(3'b100); end
            default: ;
        endcase
        taken = (o == BEQ && z) || (o == BNE && !z) || (o == BLTZ && s);
        @(posedge CLK);
        #1;
        bus.op = o;
        bus.zero = z;
        bus.sign = s;
        if (rel) Reset = 1'b1;
        for (int k = 0; k < seq.size(); k++) begin
            @(negedge CLK);
            last = (k == seq.size() - 1);
            rw = (k == 1 && o == JAL) || (last && (cls == C_ALU || cls == C_LW));
            pcs = 2'b00;
            if (k == 1 && (o == J || o == JAL)) pcs = 2'b11;
            else if (k == 1 && o == JR) pcs = 2'b10;
            else if (k == 2 && cls == C_BR) pcs = taken ? 2'b01 : 2'b00;
            chk($sformatf("state op=%b k=%0d", o, k), bus.state, seq[k]);
            chk($sformatf("PCWre op=%b k=%0d", o, k), bus.PCWre, last);
            chk($sformatf("IRWre op=%b k=%0d", o, k), bus.IRWre, k == 0);
            chk($sformatf("RegWre op=%b k=%0d", o, k), bus.RegWre, rw);
            chk($sformatf("mWR op=%b k=%0d", o, k), bus.mWR, cls == C_SW && k == 3);
            chk($sformatf("mRD op=%b k=%0d", o, k), bus.mRD, cls == C_LW && k == 3);
            chk($sformatf("DBDataSrc op=%b k=%0d", o, k), bus.DBDataSrc, cls == C_LW && k >= 3);
            chk($sformatf("PCSrc op=%b k=%0d", o, k), bus.PCSrc, pcs);
            chk($sformatf("ALUOp op=%b k=%0d", o, k), bus.ALUOp, exp_aluop(o));
            chk($sformatf("ALUSrcA op=%b k=%0d", o, k), bus.ALUSrcA, o == SLL);
            chk($sformatf("ALUSrcB op=%b k=%0d", o, k), bus.ALUSrcB,
                o == ADDI || o == ORI || o == SLTI || o == SW || o == LW);
            chk($sformatf("ExtSel op=%b k=%0d", o, k), bus.ExtSel, o != ORI);
            chk($sformatf("InsMemRW op=%b k=%0d", o, k), bus.InsMemRW, 1'b1);
            if (rw) begin
                chk($sformatf("RegDst op=%b k=%0d", o, k), bus.RegDst,
                    (o == JAL) ? 2'b00 : (o == LW || o == ADDI || o == ORI || o == SLTI) ? 2'b01 : 2'b10);
                chk($sformatf("WrRegDSrc op=%b k=%0d", o, k), bus.WrRegDSrc, o != JAL);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " state"}, bus.state, 3'b000);
        chk({tag, " PCWre"}, bus.PCWre, 1'b0);
        chk({tag, " IRWre"}, bus.IRWre, 1'b0);
        chk({tag, " RegWre"}, bus.RegWre, 1'b0);
        chk({tag, " mWR"}, bus.mWR, 1'b0);
        chk({tag, " mRD"}, bus.mRD, 1'b0);
    endtask

    initial begin
        logic [5:0] o;
        Reset = 1'b0;
        bus.op = ADD;
        bus.zero = 1'b0;
        bus.sign = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk_reset_outputs("reset");
        end

        do_instr(ADD, 1'b0, 1'b0, 1'b1);
        do_instr(LW, 1'b0, 1'b0, 1'b0);
        do_instr(BEQ, 1'b1, 1'b0, 1'b0);
        do_instr(BEQ, 1'b0, 1'b0, 1'b0);
        do_instr(JAL, 1'b0, 1'b0, 1'b0);
        do_instr(BLTZ, 1'b0, 1'b1, 1'b0);
        do_instr(BNE, 1'b0, 1'b0, 1'b0);
        do_instr(6'b101010, 1'b0, 1'b0, 1'b0);

        // halt holds ID until an asynchronous reset pulse
        @(posedge CLK);
        #1;
        bus.op = HALT;
        @(negedge CLK);
        chk("halt IF state", bus.state, 3'b000);
        repeat (10) begin
            @(negedge CLK);
            chk("halt state", bus.state, 3'b001);
            chk("halt PCWre", bus.PCWre, 1'b0);
        end
        #2;
        Reset = 1'b0;
        #1;
        chk_reset_outputs("halt async reset");
        @(negedge CLK);
        chk_reset_outputs("halt held reset");
        do_instr(SUB, 1'b0, 1'b0, 1'b1);

        // sw aborted by reset during EXE_LS
        @(posedge CLK);
        #1;
        bus.op = SW;
        @(negedge CLK);
        chk("abort IF", bus.state, 3'b000);
        @(negedge CLK);
        chk("abort ID", bus.state, 3'b001);
        @(negedge CLK);
        chk("abort EXE_LS", bus.state, 3'b010);
        #1;
        Reset = 1'b0;
        #1;
        chk_reset_outputs("abort async");
        repeat (2) begin
            @(negedge CLK);
            chk_reset_outputs("abort held");
        end
        do_instr(SW, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 4) == 0) o = 6'($urandom_range(0, 63));
            else o = legal_ops[$urandom_range(0, 16)];
            if (o == HALT) o = ADD;
            do_instr(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Moore/Mealy control FSM for the multi-cycle CPU datapath.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the register file's `RegWre`/`RegDst`/`WrRegDSrc`, plus PC, IR, ALU and data-memory controls.
- Sits beside the datapath; its inputs are the IR opcode and the ALU `zero`/`sign` flags.

Parameters:
- `STATE_W`, 3, state register width; fixed encoding below.

Ports:
- `CLK`  in  1  system clock, posedge state update.
- `Reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode from the IR (`IR[31:26]`).
- `zero`  in  1  ALU result == 0.
- `sign`  in  1  ALU result bit 31.
- `state`  out  3  current state, debug visibility.
- `PCWre`  out  1  PC load enable.
- `IRWre`  out  1  IR load enable.
- `InsMemRW`  out  1  instruction memory read, constant 1.
- `ExtSel`  out  1  1 = sign-extend immediate, 0 = zero-extend.
- `ALUSrcA`  out  1  1 = shamt, 0 = rs data.
- `ALUSrcB`  out  1  1 = extended immediate, 0 = rt data.
- `ALUOp`  out  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 101 slt signed.
- `mRD`  out  1  data memory read.
- `mWR`  out  1  data memory write.
- `DBDataSrc`  out  1  1 = memory data, 0 = ALU result onto DB.
- `RegWre`  out  1  register file write enable.
- `RegDst`  out  2  00 = $31, 01 = rt, 10 = rd.
- `WrRegDSrc`  out  1  1 = DB, 0 = PC+4 (jal).
- `PCSrc`  out  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 jump target.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000
  - slt 100110, slti 100111, sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
  - Any other opcode is illegal.
- State encoding: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions (posedge `CLK`):
  - IF -> ID, always.
  - ID -> IF for j, jr, jal and illegal opcodes.
  - ID -> EXE_BR for beq, bne, bltz.
  - ID -> EXE_LS for sw, lw.
  - ID -> ID for halt; held until reset.
  - ID -> EXE_AL for all remaining opcodes.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> IF for sw; MEM -> WB_LD for lw.
  - WB_LD -> IF.
- Outputs are combinational from `state` and `op` (plus `zero`/`sign` for `PCSrc`). No output latency beyond that decode.
- `PCWre` is 1 only in the final state of each instruction: ID for j/jr/jal/illegal, EXE_BR, MEM for sw, WB_AL, WB_LD. PC therefore loads on the same edge that returns to IF. `PCWre` = 0 in ID for halt.
- `IRWre` = 1 only in IF.
- `RegWre` = 1 only in:
  - WB_AL: `RegDst` = 10 for R-type, 01 for addi/ori/slti; `WrRegDSrc` = 1.
  - WB_LD: `RegDst` = 01; `WrRegDSrc` = 1.
  - ID for jal: `RegDst` = 00; `WrRegDSrc` = 0.
- The register file writes on negedge inside that state. The controller holds `RegWre`/`RegDst`/`WrRegDSrc` stable for the whole state.
- `mWR` = 1 only in MEM for sw. `mRD` = 1 in MEM for lw. `DBDataSrc` = 1 in MEM and WB_LD for lw, 0 elsewhere.
- `ExtSel` = 0 for ori, 1 otherwise.
- `ALUSrcA` = 1 for sll only.
- `ALUSrcB` = 1 for addi, ori, slti, sw, lw.
- `ALUOp` values:
  - sub for beq/bne; slt for bltz, with the rt operand being $0.
  - or for or/ori; and for and; sll for sll; slt for slt/slti.
  - add for add/addi/sw/lw and as the default.
- `PCSrc` values:
  - 11 for j/jal; 10 for jr.
  - In EXE_BR: 01 if (beq & `zero`) | (bne & ~`zero`) | (bltz & `sign`), else 00.
  - 00 everywhere else.
- Reset:
  - While `Reset` = 0: `state` = IF asynchronously, and `PCWre`, `IRWre`, `RegWre`, `mWR`, `mRD` are forced 0.
  - All other outputs take their IF decode.
  - On release, the first posedge goes IF -> ID with `IRWre` having been 0, so the datapath must hold the IR reset value.
  - Reset asserted mid-instruction aborts it; no partial register or memory write occurs after the assertion.

Test Plan:
- Reset low 3 cycles, release, `op` = 000000 (add) -> `state` goes 000, 001, 110, 111, 000; `RegWre` = 1 only in 111 with `RegDst` = 10, `WrRegDSrc` = 1; `PCWre` = 1 only in 111.
- `op` = 110001 (lw) -> 000, 001, 010, 011, 100, 000; `mRD` = 1 in 011; `RegWre` = 1 and `RegDst` = 01 in 100; `ALUSrcB` = 1; `ALUOp` = 000.
- `op` = 110100 (beq) with `zero` = 1, then repeat with `zero` = 0 -> EXE_BR `PCSrc` = 01, then 00; `PCWre` = 1 both times; `RegWre`/`mWR` never 1.
- `op` = 111010 (jal) -> IF then ID only; in ID: `RegWre` = 1, `RegDst` = 00, `WrRegDSrc` = 0, `PCSrc` = 11, `PCWre` = 1.
- `op` = 111111 (halt) for 10 cycles -> `state` stays 001, `PCWre` = 0 throughout; pulse `Reset` low -> `state` = 000 immediately, without waiting for a clock edge.
- sw with `Reset` pulled low during EXE_LS -> `mWR` never asserts; `state` = 000.
